// File: rtl/mux_select_sequencer.sv
// Steps an 8:1 mux select through the enabled channels, holding each for dwell+1 cycles.
// Single-pass or continuous scans; stop aborts silently, and an exhausted mask ends the scan with a done pulse.
module mux_select_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       mode_cont,
  input  logic [7:0] en_mask,
  input  logic [3:0] dwell,
  output logic       x,
  output logic       y,
  output logic       z,
  output logic [2:0] chan,
  output logic       valid,
  output logic       busy,
  output logic       done
);

  typedef enum logic {IDLE, DWELL} state_t;

  state_t     state;
  logic [3:0] cnt;
  logic [3:0] dwell_l;
  logic       mode_l;

  // Returns {found, index} of the lowest set bit.
  function automatic logic [3:0] first_set(input logic [7:0] m);
    first_set = 4'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) first_set = {1'b1, 3'(i)};
    end
  endfunction

  logic [3:0] lo_all;
  logic [3:0] lo_above;

  assign lo_all   = first_set(en_mask);
  assign lo_above = first_set(en_mask & ~((8'd2 << chan) - 8'd1));

  assign {x, y, z} = chan;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      chan    <= 3'd0;
      cnt     <= 4'd0;
      dwell_l <= 4'd0;
      mode_l  <= 1'b0;
      valid   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !stop && lo_all[3]) begin
            state   <= DWELL;
            chan    <= lo_all[2:0];
            cnt     <= 4'd0;
            dwell_l <= dwell;
            mode_l  <= mode_cont;
            valid   <= 1'b1;
            busy    <= 1'b1;
          end
        end
        DWELL: begin
          if (stop) begin
            state <= IDLE;
            valid <= 1'b0;
            busy  <= 1'b0;
          end else if (cnt == dwell_l) begin
            // The live mask is consulted only here, so the current dwell always runs to completion.
            if (lo_above[3]) begin
              chan <= lo_above[2:0];
              cnt  <= 4'd0;
            end else if (mode_l && lo_all[3]) begin
              chan <= lo_all[2:0];
              cnt  <= 4'd0;
            end else begin
              state <= IDLE;
              valid <= 1'b0;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_select_sequencer.sv
// Scoreboard bench for mux_select_sequencer: expected select sequences are queued at stimulus time
// and popped by a negedge monitor whenever the DUT shows valid or done.
module tb_mux_select_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, stop, mode_cont;
  logic [7:0] en_mask;
  logic [3:0] dwell;
  logic       x, y, z, valid, busy, done;
  logic [2:0] chan;

  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b0;
  logic [3:0] sb_q[$];   // 0..7 = channel shown with valid, 8 = done pulse
  logic [2:0] last_chan;

  mux_select_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mode_cont(mode_cont),
    .en_mask(en_mask), .dwell(dwell), .x(x), .y(y), .z(z), .chan(chan),
    .valid(valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference scan for a constant mask: pushes one entry per valid cycle, plus a done marker if the pass ends.
  task automatic model(input logic [7:0] m, input int dw, input bit cont, input int n);
    int c, cnt, nxt;
    c = -1;
    for (int i = 7; i >= 0; i--) if (m[i]) c = i;
    cnt = 0;
    for (int k = 0; k < n; k++) begin
      sb_q.push_back(4'(c));
      last_chan = 3'(c);
      if (cnt == dw) begin
        nxt = -1;
        for (int i = 7; i > c; i--) if (m[i]) nxt = i;
        if (nxt < 0 && cont)
          for (int i = 7; i >= 0; i--) if (m[i]) nxt = i;
        if (nxt < 0) begin
          sb_q.push_back(4'd8);
          break;
        end
        c = nxt;
        cnt = 0;
      end else begin
        cnt++;
      end
    end
  endtask

  always @(negedge clk) begin
    logic [3:0] code, exp;
    if (mon_en && !rst && (valid || done)) begin
      code = valid ? {1'b0, chan} : 4'd8;
      if (sb_q.size() == 0) begin
        check_eq("sb_unexpected", code, 4'd15);
      end else begin
        exp = sb_q.pop_front();
        check_eq("sb_seq", code, exp);
      end
      check_eq("busy_vs_valid", busy, valid);
      if (valid) check_eq("xyz_vs_chan", {x, y, z}, chan);
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; mode_cont = 1'b0; en_mask = 8'h00; dwell = 4'd0;
    #12;
    check_eq("rst_chan", chan, 3'd0);
    check_eq("rst_flags", {valid, busy, done}, 3'b000);
    @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;
    cyc();

    // Full single pass, dwell 0
    en_mask = 8'hFF; dwell = 4'd0; mode_cont = 1'b0;
    model(8'hFF, 0, 1'b0, 20);
    start = 1'b1; cyc(); start = 1'b0;
    repeat (12) cyc();
    check_eq("pass_q_empty", sb_q.size(), 0);
    check_eq("pass_end_flags", {valid, busy, done}, 3'b000);

    // Continuous with gaps, dwell 2, stopped after 15 valid cycles
    en_mask = 8'b1010_0100; dwell = 4'd2; mode_cont = 1'b1;
    model(8'b1010_0100, 2, 1'b1, 15);
    start = 1'b1; cyc(); start = 1'b0;
    repeat (14) cyc();
    stop = 1'b1; cyc(); stop = 1'b0;
    check_eq("cont_stop_flags", {valid, busy, done}, 3'b000);
    check_eq("cont_stop_chan", chan, last_chan);
    check_eq("cont_q_empty", sb_q.size(), 0);

    // Stop at cycle 5 of a single pass
    en_mask = 8'hFF; dwell = 4'd1; mode_cont = 1'b0;
    model(8'hFF, 1, 1'b0, 5);
    start = 1'b1; cyc(); start = 1'b0;
    repeat (4) cyc();
    stop = 1'b1; cyc(); stop = 1'b0;
    repeat (3) cyc();
    check_eq("stop5_flags", {valid, busy, done}, 3'b000);
    check_eq("stop5_chan", chan, last_chan);
    check_eq("stop5_q_empty", sb_q.size(), 0);

    // Start with empty mask is ignored
    en_mask = 8'h00;
    start = 1'b1; cyc(); start = 1'b0;
    check_eq("empty_flags", {valid, busy, done}, 3'b000);
    check_eq("empty_chan_hold", chan, 3'd2);
    cyc();

    // Mask cleared mid-dwell in continuous mode: dwell completes, then done
    en_mask = 8'b0001_0010; dwell = 4'd3; mode_cont = 1'b1;
    model(8'b0001_0010, 3, 1'b1, 6);
    sb_q.push_back(4'd4); sb_q.push_back(4'd4); sb_q.push_back(4'd8);
    start = 1'b1; cyc(); start = 1'b0;
    repeat (5) cyc();
    en_mask = 8'h00;
    repeat (6) cyc();
    check_eq("clr_q_empty", sb_q.size(), 0);
    check_eq("clr_end_flags", {valid, busy, done}, 3'b000);

    // Asynchronous reset mid-dwell, then start+stop together, then first start after reset
    mon_en = 1'b0;
    en_mask = 8'b1000_0000; dwell = 4'd5; mode_cont = 1'b0;
    start = 1'b1; cyc(); start = 1'b0;
    cyc();
    check_eq("pre_rst_chan", chan, 3'd7);
    check_eq("pre_rst_busy", busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    check_eq("arst_chan", chan, 3'd0);
    check_eq("arst_flags", {valid, busy, done}, 3'b000);
    @(negedge clk);
    rst = 1'b0;
    en_mask = 8'hFF;
    start = 1'b1; stop = 1'b1; cyc(); start = 1'b0; stop = 1'b0;
    check_eq("start_stop_flags", {valid, busy, done}, 3'b000);
    start = 1'b1; cyc(); start = 1'b0;
    check_eq("post_rst_start", {valid, busy, chan}, {2'b11, 3'd0});
    stop = 1'b1; cyc(); stop = 1'b0;
    check_eq("final_flags", {valid, busy, done}, 3'b000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux_select_sequencer.md
MUX_SELECT_SEQUENCER -- requirements
Module: mux_select_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, named clk and rst.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  one-cycle request to begin a scan; honoured only in IDLE.
REQ-005 stop  input  1  abort request; honoured in any state.
REQ-006 mode_cont  input  1  sampled at start: 1 means continuous (wrap), 0 means single pass.
REQ-007 en_mask  input  8  channel enables; bit k enables channel k; read live at every channel advance.
REQ-008 dwell  input  4  sampled at start; each channel is held for dwell+1 cycles (1..16).
REQ-009 x, y, z  output  1 each  select lines for the downstream 8:1 mux; {x,y,z} is the channel number, x is the MSB.
REQ-010 chan  output  3  current channel, equal to {x,y,z}.
REQ-011 valid  output  1  high while the select lines address an enabled channel under dwell.
REQ-012 busy  output  1  high in state DWELL.
REQ-013 done  output  1  one-cycle pulse on completion of a single pass, or on an empty-mask stop.

Function
REQ-014 FSM states SHALL be IDLE and DWELL, and all outputs SHALL be registered.
REQ-015 IDLE -> DWELL SHALL occur when start=1, stop=0 and en_mask!=0.
- On that edge: chan is loaded with the lowest set bit of en_mask.
- The dwell counter is loaded with 0.
- The dwell value and mode_cont are latched.
REQ-016 A start with en_mask=0 SHALL be ignored: stay in IDLE, no done pulse.
REQ-017 A start in DWELL SHALL be ignored.
REQ-018 In DWELL, the counter SHALL increment each cycle; chan SHALL change only on the cycle the counter equals the latched dwell.
REQ-019 Advance rule: next chan SHALL be the lowest set bit of the current en_mask strictly above chan.
- The counter returns to 0 and valid stays 1.
REQ-020 If no enabled channel lies above chan and the latched mode is continuous, the block SHALL wrap.
- Next chan is the lowest set bit of en_mask.
- Wrapping may re-select the same channel when only one bit is set.
REQ-021 If no enabled channel lies above chan and the latched mode is single pass, the block SHALL go to IDLE.
- done=1 for exactly that one cycle.
- valid=0 and busy=0 in that same cycle.
REQ-022 If en_mask=0 at a wrap point in continuous mode, the block SHALL go to IDLE with a one-cycle done pulse.
REQ-023 stop=1 in DWELL SHALL force IDLE on the next edge, with valid=0, busy=0 and no done pulse.
REQ-024 stop SHALL take priority over start and over any advance in the same cycle.
REQ-025 In IDLE, x, y, z and chan SHALL hold the last driven channel, and valid SHALL be 0.
REQ-026 Clearing the mask bit of the current channel SHALL NOT shorten its dwell; the mask takes effect only at the advance.
REQ-027 Latency from the start edge to the first valid select SHALL be one clock.

Reset
REQ-028 While rst=1, regardless of clk, the block SHALL force:
- state IDLE;
- chan, x, y, z = 0;
- valid, busy, done = 0;
- dwell counter = 0;
- latched dwell = 0 and latched mode = 0.
REQ-029 Reset asserted mid-scan SHALL abort immediately with no done pulse.
REQ-030 After rst deasserts, the first start SHALL be honoured on the first rising edge.

Verification
REQ-031 en_mask=8'hFF, dwell=0, mode_cont=0, start pulse -> chan=0..7, one cycle each, valid=1 for 8 cycles, then done=1 for one cycle and busy=0.
REQ-032 en_mask=8'b1010_0100, dwell=2, mode_cont=1 -> chan sequence 2,5,7,2,5,... with each held 3 cycles; no done pulse.
REQ-033 Scan running, stop=1 at cycle 5 -> IDLE the next cycle, done=0, chan holds its last value.
REQ-034 en_mask=0 with a start pulse -> no state change, valid=0, done=0.
REQ-035 Continuous scan, en_mask cleared to 0 mid-scan -> current dwell completes, then IDLE with a one-cycle done pulse.
REQ-036 rst asserted mid-dwell between clock edges -> outputs go to 0 immediately; then start together with stop -> remains IDLE.
